// File: rtl/regfile_pkg.sv
// Shared types and default constants for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_SP_IDX  = 29;
  localparam int DEF_SP_INIT = 252;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero/bypass select followed by the output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              elk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] sel_p0;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;

  // Select R0 zero, the same-edge write value, or the stored value.
  always_comb begin
    sel_p0 = arr_data;
    if (addr == '0)
      sel_p0 = '0;
    else if (byp_en && (byp_addr == addr))
      sel_p0 = byp_data;
  end

  // ---- stage p0 -> p1: output register, data held when not reading ----
  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en)
        data_p1 <= sel_p0;
    end
  end

  assign rd_data  = data_p1;
  assign rd_valid = vld_p1;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, hardwired R0, SP reset
// value and a one-register-per-cycle clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int SP_IDX  = DEF_SP_IDX,
  parameter int SP_INIT = DEF_SP_INIT
) (
  input  logic                     elk,
  input  logic                     nrst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] SP_A     = ADDR_W'(SP_IDX);
  localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] regs [NUM_REGS];
  state_t            state;
  logic [ADDR_W-1:0] ctr;
  logic              wr_ok;

  // A write lands only outside the sweep and never on R0.
  assign wr_ok = wr_en && (wr_addr != '0) && (state == IDLE);

  // Clear sequencer with registered busy and write-drop flag.
  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      state  <= IDLE;
      ctr    <= ADDR_W'(1);
      busy   <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ctr == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
            ctr   <= ADDR_W'(1);
          end else begin
            ctr <= ctr + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: reset image, sweep writes, then accepted writes.
  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == SP_IDX) ? SP_VAL : '0;
    end else if (state == CLEAR) begin
      regs[ctr] <= (ctr == SP_A) ? SP_VAL : '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[g*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_port (
      .elk      (elk),
      .nrst     (nrst),
      .arr_data (regs[addr]),
      .byp_en   (wr_ok),
      .byp_addr (wr_addr),
      .byp_data (wr_data),
      .rd_en    (rd_en[g]),
      .addr     (addr),
      .rd_data  (rd_data[g*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors, literal checks and a per-cycle
// comparison against an array-level behavioural model.
module tb_regfile_mp;

  logic        elk;
  logic        nrst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        clr_req;
  logic        busy;
  logic        wr_err;

  logic        w4_en;
  logic [4:0]  w4_addr;
  logic [15:0] w4_data;
  logic [3:0]  r4_en;
  logic [19:0] r4_addr;
  logic [63:0] r4_data;
  logic [3:0]  r4_valid;
  logic        busy4;
  logic        err4;

  int errors = 0;
  int checks = 0;
  bit run    = 0;

  regfile_mp dut (
    .elk(elk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
  );

  regfile_mp #(.DATA_W(16), .NUM_RD(4)) dut4 (
    .elk(elk), .nrst(nrst), .wr_en(w4_en), .wr_addr(w4_addr), .wr_data(w4_data),
    .rd_en(r4_en), .rd_addr(r4_addr), .rd_data(r4_data), .rd_valid(r4_valid),
    .clr_req(1'b0), .busy(busy4), .wr_err(err4)
  );

  initial elk = 0;
  always #5 elk = ~elk;

  // Model: plain array, a count of sweep cycles left, and output images.
  logic [31:0] mem [32];
  int          sweep_left;
  logic [31:0] m_rd [2];
  logic [1:0]  m_vld;
  logic        m_busy;
  logic        m_err;

  always @(posedge elk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < 32; i++) mem[i] = (i == 29) ? 32'd252 : 32'd0;
      sweep_left = 0;
      m_rd[0] = 0; m_rd[1] = 0;
      m_vld = 0; m_busy = 0; m_err = 0;
    end else begin
      logic accepted;
      accepted = wr_en && (wr_addr != 0) && (sweep_left == 0);
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        if (rd_en[p]) begin
          if (a == 0) m_rd[p] = 0;
          else if (accepted && wr_addr == a) m_rd[p] = wr_data;
          else m_rd[p] = mem[a];
        end
      end
      m_vld = rd_en;
      m_err = wr_en && !accepted;
      if (sweep_left > 0) begin
        int idx;
        idx = 32 - sweep_left;
        mem[idx] = (idx == 29) ? 32'd252 : 32'd0;
        sweep_left--;
      end else begin
        if (accepted) mem[wr_addr] = wr_data;
        if (clr_req) sweep_left = 31;
      end
      m_busy = (sweep_left > 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge elk) begin
    if (run && !nrst) begin
      chk("model_rd_data", rd_data, {m_rd[1], m_rd[0]});
      chk("model_rd_valid", {62'd0, rd_valid}, {62'd0, m_vld});
      chk("model_busy", {63'd0, busy}, {63'd0, m_busy});
      chk("model_wr_err", {63'd0, wr_err}, {63'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge elk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; clr_req = 0;
  endtask

  task automatic count_busy(input int start, output int n);
    n = start;
    for (int k = 0; k < 100 && busy; k++) begin
      tick();
      if (busy) n++;
    end
  endtask

  initial begin
    int n;
    nrst = 1;
    idle_inputs();
    rd_addr = 0;
    w4_en = 0; w4_addr = 0; w4_data = 0; r4_en = 0; r4_addr = 0;
    #2;
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_valid_busy_err", {61'd0, rd_valid, busy, wr_err}, 64'd0);
    tick(); tick();
    nrst = 0;
    run  = 1;

    // Reset values: port0 R29, port1 R5.
    rd_en = 2'b11; rd_addr = {5'd5, 5'd29};
    tick();
    chk("sp_reset", rd_data[31:0], 64'd252);
    chk("r5_reset", rd_data[63:32], 64'd0);
    chk("valid_once", {62'd0, rd_valid}, 64'd3);
    rd_en = 0;
    tick();
    chk("valid_drop", {62'd0, rd_valid}, 64'd0);
    chk("data_hold", rd_data[31:0], 64'd252);

    // Same-edge bypass on both ports.
    wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    tick();
    chk("bypass_p0", rd_data[31:0], 64'hDEADBEEF);
    chk("bypass_p1", rd_data[63:32], 64'hDEADBEEF);
    wr_en = 0; rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    chk("r7_later", rd_data[31:0], 64'hDEADBEEF);

    // Write to R0 is dropped.
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
    rd_en = 2'b01; rd_addr = 0;
    tick();
    chk("r0_wr_err", {63'd0, wr_err}, 64'd1);
    chk("r0_reads_zero", rd_data[31:0], 64'd0);
    idle_inputs();
    tick();
    chk("wr_err_pulse", {63'd0, wr_err}, 64'd0);

    // Fill R1..R31 with their index, then clear.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    idle_inputs();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd17};
    tick();
    chk("fill_r17", rd_data[31:0], 64'd17);
    rd_en = 0; clr_req = 1;
    tick();
    clr_req = 0;
    chk("busy_start", {63'd0, busy}, 64'd1);
    wr_en = 1; wr_addr = 3; wr_data = 32'h55;
    tick();
    chk("clear_wr_err", {63'd0, wr_err}, 64'd1);
    wr_en = 0;
    count_busy(2, n);
    chk("busy_len", 64'(n), 64'd31);
    for (int i = 1; i < 32; i++) begin
      rd_en = 2'b11; rd_addr = {5'(32 - i), 5'(i)};
      tick();
      chk("cleared_p0", rd_data[31:0], (i == 29) ? 64'd252 : 64'd0);
      chk("cleared_p1", rd_data[63:32], (i == 3) ? 64'd252 : 64'd0);
    end
    idle_inputs();

    // Reset in the middle of a sweep.
    wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    tick();
    idle_inputs();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int k = 0; k < 9; k++) tick();
    #2;
    nrst = 1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_rd", {62'd0, rd_valid}, 64'd0);
    tick();
    nrst = 0;
    rd_en = 2'b11; rd_addr = {5'd9, 5'd29};
    tick();
    chk("abort_sp", rd_data[31:0], 64'd252);
    chk("abort_r9", rd_data[63:32], 64'd0);
    idle_inputs();
    clr_req = 1;
    tick();
    clr_req = 0;
    count_busy(1, n);
    chk("busy_len_after_abort", 64'(n), 64'd31);

    // Four-port, 16-bit instance.
    w4_en = 1; w4_addr = 1; w4_data = 16'h00AA;
    tick();
    w4_addr = 2; w4_data = 16'h00BB;
    tick();
    w4_en = 0;
    r4_en = 4'hF; r4_addr = {5'd0, 5'd1, 5'd2, 5'd1};
    tick();
    chk("p4_data", r4_data, 64'h0000_00AA_00BB_00AA);
    chk("p4_valid", {60'd0, r4_valid}, 64'hF);
    r4_en = 0;
    tick();

    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port general-purpose register file for the core's decode/execute boundary.
- Reads are registered: 1-cycle latency with a per-port valid flag.
- Write-to-read bypass in the same cycle.
- R0 is hardwired to zero; the stack-pointer register has a reset value.
- A sequencer clears the whole file on request, one register per cycle.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, number of read ports
- SP_IDX, 29, index of the stack-pointer register
- SP_INIT, 252, value loaded into SP_IDX on reset and on clear

Ports:
- elk  input  1  clock, all state updates on the rising edge
- nrst  input  1  reset, asynchronous, active-high (despite the name): 1 = reset asserted
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write register index
- wr_data  input  DATA_W  write value
- rd_en  input  NUM_RD  per-port read request
- rd_addr  input  NUM_RD*ADDR_W  packed read indices; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed registered read data
- rd_valid  output  NUM_RD  rd_data for port i was updated on the last edge
- clr_req  input  1  single-cycle pulse that starts a full clear
- busy  output  1  clear sequence in progress
- wr_err  output  1  one-cycle pulse: the write requested on the previous edge was dropped

Behaviour:
- Reset (nrst=1, asynchronous):
  - all registers become 0, except reg[SP_IDX] = SP_INIT
  - rd_data = 0, rd_valid = 0, busy = 0, wr_err = 0
  - FSM goes to IDLE and the clear counter goes to 1
  - Reset asserted mid-clear aborts the clear immediately with the same values.
- Write (posedge): when wr_en=1, wr_addr!=0 and state=IDLE, reg[wr_addr] <= wr_data.
  - wr_addr=0 drops the write; wr_err=1 the next cycle.
  - A write while state=CLEAR is also dropped with wr_err=1.
  - wr_err is 0 in every other cycle.
- Read (posedge), per port i, when rd_en[i]=1:
  - addr=0 -> 0
  - else, if a write to the same addr is accepted on this edge -> wr_data (bypass, new value)
  - else -> reg[addr]
  - rd_valid[i] <= rd_en[i]. When rd_en[i]=0, rd_data[i] holds its previous value.
  - Ports are independent; all ports may read the same address.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1; busy=1 from the next cycle.
  - In CLEAR, each edge: reg[ctr] <= (ctr==SP_IDX ? SP_INIT : 0); ctr++.
  - After ctr = NUM_REGS-1 is written, return to IDLE with busy=0 and ctr=1. The sequence lasts exactly NUM_REGS-1 cycles.
  - clr_req while in CLEAR is ignored.
  - A write accepted on the same edge clr_req is sampled in IDLE completes, and is later cleared by the sweep.
- Reads during CLEAR return live array contents (already-swept entries read 0 or SP_INIT); bypass is inactive because no writes are accepted.
- Widths: no arithmetic. wr_addr and rd_addr are always in range because NUM_REGS = 2**ADDR_W.

Decomposition:
- Package regfile_pkg:
  - FSM state enum (IDLE, CLEAR)
  - default constants for DATA_W, ADDR_W, SP_IDX, SP_INIT
- Sub-module regfile_rd_port: one per read port, generated NUM_RD times.
  - Inputs: array read value, write-bypass inputs, rd_en, addr.
  - Contains the zero/bypass mux and the rd_data/rd_valid registers.

Test Plan:
- Reset with nrst=1 then release; read R29 and R5 -> rd_data = 252 and 0 one cycle after rd_en; rd_valid=1 for exactly that cycle.
- Write 0xDEADBEEF to R7; same cycle, port0 reads R7 and port1 reads R7 -> both ports return 0xDEADBEEF next cycle (bypass). A later read of R7 also returns 0xDEADBEEF.
- Write 0x1234 to R0 -> wr_err=1 for one cycle; a read of R0 returns 0.
- Fill R1..R31 with their index; pulse clr_req.
  - busy=1 for exactly 31 cycles.
  - A write to R3 during busy is dropped, with wr_err=1.
  - Afterwards R1..R31 read 0, except R29 reads 252.
- Start a clear, assert nrst at sweep cycle 10 -> busy=0 immediately; all registers at reset values; a new clr_req then runs the full 31 cycles.
- NUM_RD=4, DATA_W=16 instance: four ports read R1, R2, R1, R0 after writes of 0x00AA and 0x00BB -> 0x00AA, 0x00BB, 0x00AA, 0x0000.
